alu_writeback: RTL and testbench

Stage directly downstream of `alu`. Registers one ALU result per handshake and merges it into the destination register value according to operand size (byte/word/long). Holds the architectural condition-code register (XNZVC), which feeds back into the ALU's `in_xnzvc`, and evaluates the 16 branch conditions from it. Sits between the ALU and the register-file write port; it is the only owner of CCR state.

---
 rtl/cpu_pkg.sv | 49 ++++
 rtl/cc_eval.sv | 41 ++++
 rtl/alu_writeback.sv | 79 +++++++
 tb/tb_alu_writeback.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU encodings: operand sizes, CCR flag positions, condition codes,
// and the writeback entry type used between the ALU stage and the register file.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_WORD = 2'b01;
  localparam logic [1:0] SZ_LONG = 2'b10;

  localparam int pos_X = 4;
  localparam int pos_N = 3;
  localparam int pos_Z = 2;
  localparam int pos_V = 1;
  localparam int pos_C = 0;

  localparam logic [3:0] CC_T  = 4'h0;
  localparam logic [3:0] CC_F  = 4'h1;
  localparam logic [3:0] CC_HI = 4'h2;
  localparam logic [3:0] CC_LS = 4'h3;
  localparam logic [3:0] CC_CC = 4'h4;
  localparam logic [3:0] CC_CS = 4'h5;
  localparam logic [3:0] CC_NE = 4'h6;
  localparam logic [3:0] CC_EQ = 4'h7;
  localparam logic [3:0] CC_VC = 4'h8;
  localparam logic [3:0] CC_VS = 4'h9;
  localparam logic [3:0] CC_PL = 4'hA;
  localparam logic [3:0] CC_MI = 4'hB;
  localparam logic [3:0] CC_GE = 4'hC;
  localparam logic [3:0] CC_LT = 4'hD;
  localparam logic [3:0] CC_GT = 4'hE;
  localparam logic [3:0] CC_LE = 4'hF;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        we;
  } wb_entry_t;

  // Size 11 is treated as long.
  function automatic logic [31:0] size_merge(input logic [1:0] size,
                                             input logic [31:0] old,
                                             input logic [31:0] res);
    case (size)
      SZ_BYTE: size_merge = {old[31:8], res[7:0]};
      SZ_WORD: size_merge = {old[31:16], res[15:0]};
      default: size_merge = res;
    endcase
  endfunction

endpackage

// File: rtl/cc_eval.sv
// Combinational condition-code evaluator: CCR + cc_sel -> condition true.
// Also used by the decoder for DBcc/Scc.
module cc_eval
  import cpu_pkg::*;
(
  input  logic [4:0] ccr,
  input  logic [3:0] cc_sel,
  output logic       cc_true
);

  logic n, z, v, c;

  assign n = ccr[pos_N];
  assign z = ccr[pos_Z];
  assign v = ccr[pos_V];
  assign c = ccr[pos_C];

  always_comb begin
    cc_true = 1'b0;
    case (cc_sel)
      CC_T:    cc_true = 1'b1;
      CC_F:    cc_true = 1'b0;
      CC_HI:   cc_true = !c & !z;
      CC_LS:   cc_true = c | z;
      CC_CC:   cc_true = !c;
      CC_CS:   cc_true = c;
      CC_NE:   cc_true = !z;
      CC_EQ:   cc_true = z;
      CC_VC:   cc_true = !v;
      CC_VS:   cc_true = v;
      CC_PL:   cc_true = !n;
      CC_MI:   cc_true = n;
      CC_GE:   cc_true = (n == v);
      CC_LT:   cc_true = (n != v);
      CC_GT:   cc_true = !z & (n == v);
      CC_LE:   cc_true = z | (n != v);
      default: cc_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback stage: one-entry result register with size merge, plus the
// architectural CCR (sole owner) and branch-condition evaluation from it.
module alu_writeback
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_alu_size,
  input  logic [31:0] in_result,
  input  logic [4:0]  in_xnzvc,
  input  logic [4:0]  in_ccr_mask,
  input  logic        in_z_sticky,
  input  logic [31:0] in_dest_old,
  input  logic [3:0]  in_dest_reg,
  input  logic        in_dest_we,
  input  logic        ccr_wr,
  input  logic [4:0]  ccr_wdata,
  input  logic [3:0]  cc_sel,
  output logic [4:0]  out_xnzvc,
  output logic        out_cc_true,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [3:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        wb_we
);

  logic      accept;
  logic [4:0] ccr, ccr_next;
  wb_entry_t  wb_q;

  assign in_ready = !wb_valid | wb_ready;
  assign accept   = in_valid & in_ready;

  // Direct CCR write overrides any flag update from a same-cycle accept.
  always_comb begin
    ccr_next = ccr;
    if (accept) begin
      for (int i = 0; i < 5; i++)
        if (in_ccr_mask[i]) ccr_next[i] = in_xnzvc[i];
      if (in_ccr_mask[pos_Z] && in_z_sticky)
        ccr_next[pos_Z] = ccr[pos_Z] & in_xnzvc[pos_Z];
    end
    if (ccr_wr) ccr_next = ccr_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ccr <= '0;
    else        ccr <= ccr_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_q     <= '0;
    end else if (accept) begin
      wb_valid  <= 1'b1;
      wb_q.rd   <= in_dest_reg;
      wb_q.we   <= in_dest_we;
      wb_q.data <= size_merge(in_alu_size, in_dest_old, in_result);
    end else if (wb_ready) begin
      wb_valid <= 1'b0;
    end
  end

  assign wb_reg    = wb_q.rd;
  assign wb_data   = wb_q.data;
  assign wb_we     = wb_q.we;
  assign out_xnzvc = ccr;

  cc_eval u_cc_eval (
    .ccr     (ccr),
    .cc_sel  (cc_sel),
    .cc_true (out_cc_true)
  );

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: driver pushes expected writeback entries
// and tracks CCR; a negedge monitor compares every cycle and pops on drain.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_alu_size;
  logic [31:0] in_result;
  logic [4:0]  in_xnzvc;
  logic [4:0]  in_ccr_mask;
  logic        in_z_sticky;
  logic [31:0] in_dest_old;
  logic [3:0]  in_dest_reg;
  logic        in_dest_we;
  logic        ccr_wr;
  logic [4:0]  ccr_wdata;
  logic [3:0]  cc_sel;
  logic [4:0]  out_xnzvc;
  logic        out_cc_true;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_reg;
  logic [31:0] wb_data;
  logic        wb_we;

  alu_writeback dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_size(in_alu_size), .in_result(in_result), .in_xnzvc(in_xnzvc),
    .in_ccr_mask(in_ccr_mask), .in_z_sticky(in_z_sticky),
    .in_dest_old(in_dest_old), .in_dest_reg(in_dest_reg),
    .in_dest_we(in_dest_we), .ccr_wr(ccr_wr), .ccr_wdata(ccr_wdata),
    .cc_sel(cc_sel), .out_xnzvc(out_xnzvc), .out_cc_true(out_cc_true),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_reg(wb_reg),
    .wb_data(wb_data), .wb_we(wb_we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] data;
    logic        we;
  } exp_t;

  exp_t       q[$];
  logic [4:0] mccr;
  int         n_checks = 0;
  int         n_pass   = 0;
  bit         mon_on   = 0;
  logic [31:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Condition semantics written from flag meanings (N,Z,V,C by name).
  function automatic logic cond(input logic [3:0] s, input logic [4:0] f);
    bit n, z, v, c;
    n = f[3]; z = f[2]; v = f[1]; c = f[0];
    case (s)
      0: return 1;           1: return 0;
      2: return !c && !z;    3: return c || z;
      4: return !c;          5: return c;
      6: return !z;          7: return z;
      8: return !v;          9: return v;
      10: return !n;         11: return n;
      12: return n == v;     13: return n != v;
      14: return !z && (n == v);
      default: return z || (n != v);
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [1:0] sz, input logic [31:0] old, input logic [31:0] res);
    if (sz == 0) return (old & 32'hFFFF_FF00) | (res & 32'h0000_00FF);
    if (sz == 1) return (old & 32'hFFFF_0000) | (res & 32'h0000_FFFF);
    return res;
  endfunction

  // Monitor: every negedge compare handshake, CCR, condition and queue head.
  always @(negedge clk) begin
    if (mon_on) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, (q.size() == 0) || wb_ready});
      check("wb_valid", {31'b0, wb_valid}, {31'b0, q.size() != 0});
      check("ccr", {27'b0, out_xnzvc}, {27'b0, mccr});
      check("cc_true", {31'b0, out_cc_true}, {31'b0, cond(cc_sel, mccr)});
      if (q.size() > 0) begin
        check("wb_data", wb_data, q[0].data);
        check("wb_reg", {28'b0, wb_reg}, {28'b0, q[0].rd});
        check("wb_we", {31'b0, wb_we}, {31'b0, q[0].we});
        if (wb_ready) void'(q.pop_front());
      end
    end
  end

  // Advance one clock; record what the DUT should have taken at this edge.
  task automatic tick();
    bit acc;
    @(posedge clk);
    acc = rst_n && in_valid && (q.size() == 0);
    if (acc) begin
      exp_t e;
      e.rd = in_dest_reg; e.we = in_dest_we;
      e.data = merge(in_alu_size, in_dest_old, in_result);
      q.push_back(e);
    end
    if (rst_n) begin
      if (ccr_wr) mccr = ccr_wdata;
      else if (acc) begin
        for (int i = 0; i < 5; i++) begin
          if (in_ccr_mask[i]) begin
            if (i == 2 && in_z_sticky) mccr[i] = mccr[i] && in_xnzvc[i];
            else mccr[i] = in_xnzvc[i];
          end
        end
      end
    end
    #1;
  endtask

  task automatic set_in(input logic v, input logic [1:0] sz, input logic [31:0] res,
                        input logic [4:0] f, input logic [4:0] m, input logic st,
                        input logic [31:0] old, input logic [3:0] rd, input logic we);
    in_valid = v; in_alu_size = sz; in_result = res; in_xnzvc = f;
    in_ccr_mask = m; in_z_sticky = st; in_dest_old = old; in_dest_reg = rd; in_dest_we = we;
  endtask

  initial begin
    rst_n = 0; wb_ready = 1; ccr_wr = 0; ccr_wdata = 0; cc_sel = 0; mccr = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #12;
    check("rst_ccr", {27'b0, out_xnzvc}, 32'h0);
    check("rst_wb_valid", {31'b0, wb_valid}, 32'h0);
    check("rst_wb_data", wb_data, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_cc_T", {31'b0, out_cc_true}, 32'h1);
    cc_sel = 1; #1;
    check("rst_cc_F", {31'b0, out_cc_true}, 32'h0);
    @(posedge clk); #1; rst_n = 1; mon_on = 1;
    tick();

    // Byte add, flags N only.
    set_in(1, 2'b00, 32'h0000_00FF, 5'b01000, 5'b11111, 0, 32'h1234_5678, 4'd3, 1);
    tick(); in_valid = 0;
    check("byte_data", wb_data, 32'h1234_56FF);
    check("byte_ccr", {27'b0, out_xnzvc}, 32'h08);
    cc_sel = 4'hB; #1; check("cc_MI", {31'b0, out_cc_true}, 32'h1);
    cc_sel = 4'hA; #1; check("cc_PL", {31'b0, out_cc_true}, 32'h0);
    tick();

    // Word / long / size 11 merges back to back.
    set_in(1, 2'b01, 32'h1111_2222, 5'b00000, 5'b00000, 0, 32'hAAAA_5555, 4'd1, 1);
    tick(); check("word_data", wb_data, 32'hAAAA_2222);
    in_alu_size = 2'b10; tick(); check("long_data", wb_data, 32'h1111_2222);
    in_alu_size = 2'b11; tick(); check("sz11_data", wb_data, 32'h1111_2222);
    in_valid = 0; tick();

    // Sticky Z: set Z, then sticky with Z_in=0 clears, Z_in=1 keeps clear.
    set_in(1, 2'b10, 0, 5'b00100, 5'b11111, 0, 0, 4'd0, 0);
    tick(); check("z_set", {31'b0, out_xnzvc[2]}, 32'h1);
    set_in(1, 2'b10, 0, 5'b00000, 5'b00100, 1, 0, 4'd0, 0);
    tick(); check("z_sticky0", {31'b0, out_xnzvc[2]}, 32'h0);
    set_in(1, 2'b10, 0, 5'b00100, 5'b00100, 1, 0, 4'd0, 0);
    tick(); check("z_sticky1", {31'b0, out_xnzvc[2]}, 32'h0);
    in_valid = 0; tick();

    // Back-pressure: stall 3 cycles, then drain and accept together.
    wb_ready = 0;
    set_in(1, 2'b10, 32'hDEAD_BEEF, 5'b10001, 5'b11111, 0, 0, 4'd7, 1);
    tick(); held = wb_data;
    set_in(1, 2'b10, 32'hCAFE_F00D, 5'b01110, 5'b11111, 0, 0, 4'd8, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_in_ready", {31'b0, in_ready}, 32'h0);
      check("bp_hold", wb_data, held);
      check("bp_ccr", {27'b0, out_xnzvc}, 32'h11);
    end
    wb_ready = 1; tick(); in_valid = 0;
    check("bp_nobubble_v", {31'b0, wb_valid}, 32'h1);
    check("bp_nobubble_d", wb_data, 32'hCAFE_F00D);
    tick();

    // Direct CCR write wins over a same-cycle accept.
    set_in(1, 2'b10, 32'h0000_0042, 5'b01010, 5'b11111, 0, 0, 4'd5, 1);
    ccr_wr = 1; ccr_wdata = 5'b10101;
    tick(); ccr_wr = 0; in_valid = 0;
    check("ccrwr_ccr", {27'b0, out_xnzvc}, 32'h15);
    check("ccrwr_wb", {31'b0, wb_valid}, 32'h1);
    tick();

    // Async reset mid-stall drops the pending entry immediately.
    wb_ready = 0;
    set_in(1, 2'b10, 32'h0BAD_0BAD, 0, 0, 0, 0, 4'd2, 1);
    tick(); in_valid = 0;
    #2 rst_n = 0; #1;
    check("rst_mid_valid", {31'b0, wb_valid}, 32'h0);
    q.delete(); mccr = 0; wb_ready = 1;
    @(posedge clk); #1; rst_n = 1;
    tick();

    // Randomized traffic.
    for (int k = 0; k < 400; k++) begin
      set_in($urandom_range(0, 3) != 0, 2'($urandom), $urandom, 5'($urandom),
             5'($urandom), 1'($urandom), $urandom, 4'($urandom), 1'($urandom));
      wb_ready  = $urandom_range(0, 2) != 0;
      ccr_wr    = $urandom_range(0, 9) == 0;
      ccr_wdata = 5'($urandom);
      cc_sel    = 4'($urandom);
      tick();
    end
    in_valid = 0; ccr_wr = 0; wb_ready = 1;
    for (int k = 0; k < 4; k++) tick();
    check("drain_empty", q.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
